// File: rtl/viterbi_frame_if.sv
// Handshake bundle between the symbol source / bit sink and the Viterbi frame controller.
interface viterbi_frame_if #(
   parameter int PM_W = 8
);
   logic            start;
   logic            sym_valid;
   logic            sym_ready;
   logic [1:0]      sym_data;
   logic            bit_valid;
   logic            bit_ready;
   logic            bit_data;
   logic            busy;
   logic            frame_done;
   logic [PM_W-1:0] final_metric;

   modport master (
      output start, sym_valid, sym_data, bit_ready,
      input  sym_ready, bit_valid, bit_data, busy, frame_done, final_metric
   );

   modport slave (
      input  start, sym_valid, sym_data, bit_ready,
      output sym_ready, bit_valid, bit_data, busy, frame_done, final_metric
   );
endinterface

// File: rtl/viterbi_frame_controller.sv
// Frame-level hard-decision Viterbi decoder for the K=3 (7,5) code: one registered ACS step
// per accepted symbol, traceback after the last symbol, decoded bits streamed in input order.
//
// state | meaning
// IDLE  | waiting for start
// ACS   | accepting symbols, one add-compare-select update per accept
// SEL   | pick lowest-metric end state, latch final_metric
// TRACE | walk survivors back one step per cycle, fill decoded buffer
// OUT   | stream decoded bits on the bit handshake
module viterbi_frame_controller #(
   parameter int FRAME_LEN    = 8,
   parameter int PM_W         = 8,
   parameter int INIT_PENALTY = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   viterbi_frame_if.slave   vif
);
   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [2:0] {IDLE, ACS, SEL, TRACE, OUT} state_t;

   state_t           state, state_nxt;
   logic [PM_W-1:0]  pm_q     [4];
   logic [PM_W-1:0]  pm_raw   [4];
   logic [PM_W-1:0]  pm_new   [4];
   logic [3:0]       surv_acs;
   logic [3:0]       surv_q   [FRAME_LEN];
   logic [FRAME_LEN-1:0] dec_q;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] t_idx;
   logic [1:0]       tr_s;
   logic [1:0]       best;
   logic             norm;
   logic             sym_acc;
   logic             bit_acc;

   function automatic logic [1:0] hamming(input logic [1:0] rx, input logic [1:0] code);
      logic [1:0] d;
      d = rx ^ code;
      return {1'b0, d[1]} + {1'b0, d[0]};
   endfunction

   function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
      logic [PM_W:0] s;
      s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
      return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
   endfunction

   // Predecessors of n are {n0,0} and {n0,1}; their expected codes are bitwise complements.
   for (genvar n = 0; n < 4; n++) begin : g_acs
      localparam logic [1:0] NB     = 2'(n);
      localparam logic [1:0] CODE_A = {NB[1] ^ NB[0], NB[1]};
      logic [PM_W-1:0] cand_a, cand_b;
      assign cand_a      = sat_add(pm_q[{NB[0], 1'b0}], hamming(vif.sym_data, CODE_A));
      assign cand_b      = sat_add(pm_q[{NB[0], 1'b1}], hamming(vif.sym_data, ~CODE_A));
      assign surv_acs[n] = cand_b < cand_a;
      assign pm_raw[n]   = surv_acs[n] ? cand_b : cand_a;
   end

   assign norm = pm_raw[0][PM_W-1] & pm_raw[1][PM_W-1] & pm_raw[2][PM_W-1] & pm_raw[3][PM_W-1];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pm_new[i] = pm_raw[i];
         if (norm) pm_new[i][PM_W-1] = 1'b0;
      end
   end

   always_comb begin
      best = 2'd0;
      for (int i = 1; i < 4; i++) begin
         if (pm_q[i] < pm_q[best]) best = 2'(i);
      end
   end

   assign sym_acc = (state == ACS) && vif.sym_valid;
   assign bit_acc = (state == OUT) && vif.bit_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (vif.start)                state_nxt = ACS;
         ACS:     if (sym_acc && idx == LAST)   state_nxt = SEL;
         SEL:                                   state_nxt = TRACE;
         TRACE:   if (t_idx == '0)              state_nxt = OUT;
         OUT:     if (bit_acc && idx == LAST)   state_nxt = IDLE;
         default:                               state_nxt = IDLE;
      endcase
   end

   always_comb begin
      vif.sym_ready = (state == ACS);
      vif.bit_valid = (state == OUT);
      vif.busy      = (state != IDLE);
      vif.bit_data  = (state == OUT) ? dec_q[idx] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) pm_q[i] <= '0;
         for (int i = 0; i < FRAME_LEN; i++) surv_q[i] <= '0;
         dec_q            <= '0;
         idx              <= '0;
         t_idx            <= '0;
         tr_s             <= '0;
         vif.final_metric <= '0;
         vif.frame_done   <= 1'b0;
      end else begin
         vif.frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (vif.start) begin
                  pm_q[0] <= '0;
                  for (int i = 1; i < 4; i++) pm_q[i] <= PM_W'(INIT_PENALTY);
                  idx <= '0;
               end
            end
            ACS: begin
               if (sym_acc) begin
                  for (int i = 0; i < 4; i++) pm_q[i] <= pm_new[i];
                  surv_q[idx] <= surv_acs;
                  idx         <= (idx == LAST) ? '0 : idx + IDX_W'(1);
               end
            end
            SEL: begin
               vif.final_metric <= pm_q[best];
               t_idx            <= LAST;
               tr_s             <= best;
            end
            TRACE: begin
               dec_q[t_idx] <= tr_s[1];
               tr_s         <= {tr_s[0], surv_q[t_idx][tr_s]};
               if (t_idx == '0) idx <= '0;
               else             t_idx <= t_idx - IDX_W'(1);
            end
            OUT: begin
               if (bit_acc) begin
                  if (idx == LAST) begin
                     idx            <= '0;
                     vif.frame_done <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_viterbi_frame_controller.sv
// Directed bench for viterbi_frame_controller: hand-decoded frames, backpressure, mid-frame reset.
module tb_viterbi_frame_controller;
   localparam int FRAME_LEN = 8;
   localparam int PM_W      = 8;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   viterbi_frame_if #(.PM_W(PM_W)) vif ();

   viterbi_frame_controller #(
      .FRAME_LEN    (FRAME_LEN),
      .PM_W         (PM_W),
      .INIT_PENALTY (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vif   (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_syms(input logic [1:0] syms[8], input int count, input int gap,
                            input logic stray, input string tag);
      int w;
      for (int i = 0; i < count; i++) begin
         vif.sym_valid = 1'b0;
         repeat (gap) @(negedge clk);
         vif.sym_valid = 1'b1;
         vif.sym_data  = syms[i];
         if (stray && i == 2) vif.start = 1'b1;
         w = 0;
         while (!vif.sym_ready && w < 100) begin
            @(negedge clk);
            w++;
         end
         chk({tag, " sym_timeout"}, 32'(w >= 100), 0);
         @(negedge clk);
         vif.start = 1'b0;
      end
      vif.sym_valid = 1'b0;
      vif.sym_data  = 2'b00;
   endtask

   task automatic run_frame(input logic [1:0] syms[8], input int gap, input int stall_bit,
                            input int stall_len, input logic stray, input logic [7:0] exp_bits,
                            input logic [7:0] exp_metric, input string tag);
      int lat;
      int w;
      logic [7:0] got;
      got = '0;
      @(negedge clk);
      vif.start = 1'b1;
      @(negedge clk);
      vif.start = 1'b0;
      send_syms(syms, FRAME_LEN, gap, stray, tag);
      lat = 0;
      while (!vif.bit_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, lat, FRAME_LEN + 1);
      chk({tag, " final_metric"}, 32'(vif.final_metric), 32'(exp_metric));
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (i == stall_bit) begin
            vif.bit_ready = 1'b0;
            repeat (stall_len) begin
               @(negedge clk);
               chk({tag, " stall_valid"}, 32'(vif.bit_valid), 1);
               chk({tag, " stall_data"}, 32'(vif.bit_data), 32'(exp_bits[i]));
            end
         end
         vif.bit_ready = 1'b1;
         if (stray && (i == 3 || i == FRAME_LEN - 1)) vif.start = 1'b1;
         w = 0;
         while (!vif.bit_valid && w < 100) begin
            @(negedge clk);
            w++;
         end
         chk({tag, " bit_timeout"}, 32'(w >= 100), 0);
         got[i] = vif.bit_data;
         @(negedge clk);
         vif.start = 1'b0;
      end
      chk({tag, " bits"}, 32'(got), 32'(exp_bits));
      chk({tag, " frame_done"}, 32'(vif.frame_done), 1);
      chk({tag, " busy_after"}, 32'(vif.busy), 0);
      @(negedge clk);
      chk({tag, " frame_done_once"}, 32'(vif.frame_done), 0);
      chk({tag, " idle_stays"}, 32'(vif.busy), 0);
   endtask

   logic [1:0] zero_f [8];
   logic [1:0] clean_f[8];
   logic [1:0] err_f  [8];

   initial begin
      zero_f  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      clean_f = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
      err_f   = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00};

      vif.start     = 1'b0;
      vif.sym_valid = 1'b0;
      vif.sym_data  = 2'b00;
      vif.bit_ready = 1'b1;
      rst_n         = 1'b0;
      #1;
      chk("rst sym_ready", 32'(vif.sym_ready), 0);
      chk("rst busy", 32'(vif.busy), 0);
      chk("rst bit_valid", 32'(vif.bit_valid), 0);
      chk("rst frame_done", 32'(vif.frame_done), 0);
      chk("rst final_metric", 32'(vif.final_metric), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // bit order: got[i] is the i-th decoded bit, clean frame decodes to 1,0,1,1,0,0,0,0
      run_frame(zero_f,  0, -1, 0, 1'b0, 8'h00, 8'd0, "zero");
      run_frame(clean_f, 0, -1, 0, 1'b0, 8'h0D, 8'd0, "clean");
      run_frame(err_f,   0, -1, 0, 1'b0, 8'h0D, 8'd1, "single_err");
      run_frame(clean_f, 3,  2, 5, 1'b0, 8'h0D, 8'd0, "backpressure");

      @(negedge clk);
      vif.start = 1'b1;
      @(negedge clk);
      vif.start = 1'b0;
      send_syms(clean_f, 4, 0, 1'b0, "midrst");
      chk("midrst in_acs", 32'(vif.sym_ready), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst sym_ready", 32'(vif.sym_ready), 0);
      chk("midrst busy", 32'(vif.busy), 0);
      chk("midrst bit_valid", 32'(vif.bit_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(clean_f, 0, -1, 0, 1'b0, 8'h0D, 8'd0, "after_rst");

      run_frame(zero_f,  1, -1, 0, 1'b1, 8'h00, 8'd0, "stray_start");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
